mpadder_seq: RTL and testbench

- Parametrised multi-cycle, multi-precision adder/subtractor for the modular-arithmetic datapath.
- Splits WIDTH-bit operands into CHUNK_W-bit limbs and processes one limb per clock, rippling the carry through a register.
- Trades latency for a short critical path that is independent of WIDTH.
- Adds start/busy/done handshake, operand capture, zero flag and a sign/borrow bit; the previous fixed-width single-shot adder has none of these.

---
 rtl/mpadder_pkg.sv | 21 ++
 rtl/mpadder_seq_if.sv | 23 ++
 rtl/mpadder_chunk.sv | 14 +
 rtl/mpadder_seq.sv | 111 +++++++++++
 tb/tb_mpadder_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mpadder_pkg.sv
// Shared widths, FSM encoding and helpers for the sequential multi-precision adder.
package mpadder_pkg;

   localparam int MP_WIDTH = 1027;
   localparam int MP_CHUNK = 64;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/mpadder_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multi-precision adder.
interface mpadder_seq_if #(
   parameter int WIDTH = mpadder_pkg::MP_WIDTH
);
   logic             start;
   logic             subtract;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   result;
   logic             zero;

   modport master (
      output start, subtract, in_a, in_b,
      input  busy, done, result, zero
   );

   modport slave (
      input  start, subtract, in_a, in_b,
      output busy, done, result, zero
   );
endinterface

// File: rtl/mpadder_chunk.sv
// One limb of the ripple datapath: {cout, s} = a + b + cin, purely combinational.
module mpadder_chunk #(
   parameter int CHUNK_W = mpadder_pkg::MP_CHUNK
) (
   input  logic [CHUNK_W-1:0] a,
   input  logic [CHUNK_W-1:0] b,
   input  logic               cin,
   output logic [CHUNK_W-1:0] s,
   output logic               cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};

endmodule

// File: rtl/mpadder_seq.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK_W limb per clock with the carry held in a register,
// so the critical path depends only on CHUNK_W.
module mpadder_seq
   import mpadder_pkg::*;
#(
   parameter int WIDTH   = MP_WIDTH,
   parameter int CHUNK_W = MP_CHUNK
) (
   input logic          clk,
   input logic          reset,
   mpadder_seq_if.slave bus
);

   localparam int NCHUNK   = ceil_div(WIDTH, CHUNK_W);
   localparam int PAD_W    = NCHUNK * CHUNK_W;
   localparam int CNT_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int LAST_BIT = WIDTH % CHUNK_W;
   localparam logic [PAD_W-1:0] LOW_MASK = PAD_W'({WIDTH{1'b1}});

   state_e             state;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic               sub_q;
   logic [PAD_W-1:0]   op_a;
   logic [PAD_W-1:0]   op_b;
   logic [PAD_W-1:0]   res_pad;
   logic [PAD_W-1:0]   res_next;
   logic               res_msb;
   logic               zero_q;

   logic [CHUNK_W-1:0] limb_a;
   logic [CHUNK_W-1:0] limb_b;
   logic [CHUNK_W-1:0] limb_s;
   logic               limb_c;
   logic               wide_c;
   logic               last;
   logic               accept;

   assign accept = bus.start && (state != RUN);
   assign last   = (cnt == CNT_W'(NCHUNK - 1));

   assign limb_a = op_a[int'(cnt)*CHUNK_W +: CHUNK_W];
   assign limb_b = op_b[int'(cnt)*CHUNK_W +: CHUNK_W];

   mpadder_chunk #(
      .CHUNK_W (CHUNK_W)
   ) u_chunk (
      .a    (limb_a),
      .b    (limb_b),
      .cin  (carry),
      .s    (limb_s),
      .cout (limb_c)
   );

   // Pad bits are zero, so the carry out of bit WIDTH-1 lands on sum bit LAST_BIT of the top limb.
   assign wide_c = (LAST_BIT == 0) ? limb_c : limb_s[LAST_BIT];

   always_comb begin
      res_next = res_pad;
      res_next[int'(cnt)*CHUNK_W +: CHUNK_W] = limb_s;
   end

   // Operand capture: B is inverted for subtract and the +1 enters as the initial carry.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_a <= PAD_W'(bus.in_a);
         op_b <= PAD_W'(bus.in_b ^ {WIDTH{bus.subtract}});
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         carry   <= 1'b0;
         sub_q   <= 1'b0;
         res_pad <= '0;
         res_msb <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               res_pad <= res_next;
               carry   <= limb_c;
               cnt     <= cnt + 1'b1;
               if (last) begin
                  res_msb <= wide_c ^ sub_q;
                  zero_q  <= ~|(res_next & LOW_MASK);
                  state   <= DONE;
               end
            end
            default: begin
               if (accept) begin
                  cnt   <= '0;
                  carry <= bus.subtract;
                  sub_q <= bus.subtract;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = (state == DONE);
   assign bus.result = {res_msb, res_pad[WIDTH-1:0]};
   assign bus.zero   = zero_q;

endmodule

// File: tb/tb_mpadder_seq.sv
// Bench for mpadder_seq in three configurations: 1027/64, 100/32 (partial top limb), 128/32 (exact multiple).
module tb_mpadder_seq;
   import mpadder_pkg::*;

   localparam int W0 = 1027, C0 = 64, N0 = 17;
   localparam int W1 = 100,  C1 = 32, N1 = 4;
   localparam int W2 = 128,  C2 = 32, N2 = 4;

   typedef logic [1027:0] wide_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mpadder_seq_if #(.WIDTH(W0)) if0 ();
   mpadder_seq_if #(.WIDTH(W1)) if1 ();
   mpadder_seq_if #(.WIDTH(W2)) if2 ();

   mpadder_seq #(.WIDTH(W0), .CHUNK_W(C0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
   mpadder_seq #(.WIDTH(W1), .CHUNK_W(C1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
   mpadder_seq #(.WIDTH(W2), .CHUNK_W(C2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

   task automatic check(input string tag, input wide_t got, input wide_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h..%0h exp=%0h..%0h", tag, got[1027:900], got[127:0],
                  exp[1027:900], exp[127:0]);
      end
   endtask

   function automatic int width_of(input int cfg);
      return (cfg == 0) ? W0 : (cfg == 1) ? W1 : W2;
   endfunction

   function automatic int lat_of(input int cfg);
      return (cfg == 0) ? N0 : (cfg == 1) ? N1 : N2;
   endfunction

   function automatic wide_t mask_of(input int w);
      return (wide_t'(1) << w) - wide_t'(1);
   endfunction

   // Reference: plain wide-integer arithmetic on the unsigned operands.
   function automatic wide_t model(input int w, input wide_t a, input wide_t b, input logic s);
      wide_t m, sum, low;
      logic  msb;
      m = mask_of(w);
      a = a & m;
      b = b & m;
      if (s) begin
         low = (a - b) & m;
         msb = (a < b);
      end else begin
         sum = a + b;
         low = sum & m;
         msb = sum[w];
      end
      return low | (wide_t'(msb) << w);
   endfunction

   function automatic wide_t rand_wide(input int w);
      logic [1055:0] t;
      int            k;
      k = $urandom_range(0, 7);
      for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
      if (k == 0) return '0;
      if (k == 1) return mask_of(w);
      return t[1027:0] & mask_of(w);
   endfunction

   task automatic drive(input int cfg, input logic st, input wide_t a, input wide_t b, input logic s);
      case (cfg)
         0: begin if0.start = st; if0.in_a = a[W0-1:0]; if0.in_b = b[W0-1:0]; if0.subtract = s; end
         1: begin if1.start = st; if1.in_a = a[W1-1:0]; if1.in_b = b[W1-1:0]; if1.subtract = s; end
         default: begin if2.start = st; if2.in_a = a[W2-1:0]; if2.in_b = b[W2-1:0]; if2.subtract = s; end
      endcase
   endtask

   task automatic sample(input int cfg, output logic d, output logic bz, output logic z, output wide_t r);
      r = '0;
      case (cfg)
         0: begin d = if0.done; bz = if0.busy; z = if0.zero; r = if0.result; end
         1: begin d = if1.done; bz = if1.busy; z = if1.zero; r[W1:0] = if1.result; end
         default: begin d = if2.done; bz = if2.busy; z = if2.zero; r[W2:0] = if2.result; end
      endcase
   endtask

   // One operation: start at the next edge, scramble inputs afterwards, wait (bounded) for done.
   task automatic run_op(input int cfg, input wide_t a, input wide_t b, input logic s,
                         input string tag, output wide_t r, output logic z);
      wide_t exp;
      logic  d, bz;
      int    n, w;
      w   = width_of(cfg);
      exp = model(w, a, b, s);
      @(negedge clk);
      drive(cfg, 1'b1, a, b, s);
      @(posedge clk); #1;
      drive(cfg, 1'b0, rand_wide(w), rand_wide(w), ~s);
      n = 0;
      d = 1'b0;
      while (!d && n < 200) begin
         @(posedge clk); #1;
         n++;
         sample(cfg, d, bz, z, r);
      end
      check($sformatf("%s_lat", tag), wide_t'(n), wide_t'(lat_of(cfg)));
      check($sformatf("%s_res", tag), r, exp);
      check($sformatf("%s_zero", tag), wide_t'(z), wide_t'((exp & mask_of(w)) == '0));
   endtask

   initial begin
      wide_t r, a1, b1, a3, b3, exp1, exp3, pat;
      logic  d, bz, z;
      int    dones, first, n;
      logic [1087:0] rep;

      reset = 1'b1;
      for (int c = 0; c < 3; c++) drive(c, 1'b0, '0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      sample(0, d, bz, z, r);
      check("rst_busy", wide_t'(bz), '0);
      check("rst_done", wide_t'(d), '0);
      check("rst_zero", wide_t'(z), '0);
      check("rst_result", r, '0);
      reset = 1'b0;

      run_op(0, mask_of(W0), wide_t'(1), 1'b0, "max_plus_one", r, z);
      check("max_plus_one_const", r, wide_t'(1) << W0);
      check("max_plus_one_zflag", wide_t'(z), wide_t'(1));

      run_op(0, wide_t'(5), wide_t'(7), 1'b1, "five_minus_seven", r, z);
      check("five_minus_seven_const", r, (wide_t'(1) << (W0 + 1)) - wide_t'(2));

      for (int i = 0; i < 17; i++) rep[i*64 +: 64] = 64'h1234_5678_9ABC_DEF0;
      pat = rep[1027:0] & mask_of(W0);
      run_op(0, pat, pat, 1'b1, "equal_sub", r, z);
      check("equal_sub_const", r, '0);

      // Second start 5 cycles in must be ignored; a start in the done cycle is taken immediately.
      a1 = rand_wide(W0); b1 = rand_wide(W0);
      exp1 = model(W0, a1, b1, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, a1, b1, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, '0, 1'b0);
      sample(0, d, bz, z, r);
      check("busy_after_start", wide_t'(bz), wide_t'(1));
      dones = 0;
      first = -1;
      for (int k = 1; k <= 17; k++) begin
         if (k == 5) drive(0, 1'b1, rand_wide(W0), rand_wide(W0), 1'b1);
         @(posedge clk); #1;
         if (k == 5) drive(0, 1'b0, '0, '0, 1'b0);
         sample(0, d, bz, z, r);
         if (d) begin
            dones++;
            if (first < 0) first = k;
         end
      end
      check("ignored_start_dones", wide_t'(dones), wide_t'(1));
      check("ignored_start_cycle", wide_t'(first), wide_t'(17));
      check("ignored_start_res", r, exp1);
      a3 = rand_wide(W0); b3 = rand_wide(W0);
      exp3 = model(W0, a3, b3, 1'b1);
      drive(0, 1'b1, a3, b3, 1'b1);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, '0, 1'b0);
      n = 1;
      d = 1'b0;
      while (!d && n < 200) begin
         @(posedge clk); #1;
         n++;
         sample(0, d, bz, z, r);
      end
      check("b2b_spacing", wide_t'(n), wide_t'(18));
      check("b2b_res", r, exp3);
      @(posedge clk); #1;
      sample(0, d, bz, z, r);
      check("done_one_cycle", wide_t'(d), '0);
      check("idle_not_busy", wide_t'(bz), '0);
      check("result_held", r, exp3);

      // Reset in cycle 8 of an operation aborts it.
      @(negedge clk);
      drive(0, 1'b1, rand_wide(W0), rand_wide(W0), 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, '0, 1'b0);
      repeat (7) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sample(0, d, bz, z, r);
      check("abort_busy", wide_t'(bz), '0);
      check("abort_done", wide_t'(d), '0);
      check("abort_result", r, '0);
      check("abort_zero", wide_t'(z), '0);
      dones = 0;
      repeat (25) begin
         @(posedge clk); #1;
         sample(0, d, bz, z, r);
         if (d) dones++;
      end
      check("abort_no_done", wide_t'(dones), '0);
      run_op(0, rand_wide(W0), rand_wide(W0), 1'b0, "after_abort", r, z);

      for (int i = 0; i < 30; i++)
         run_op(0, rand_wide(W0), rand_wide(W0), 1'($urandom_range(0, 1)), "rnd0", r, z);

      run_op(1, mask_of(W1), wide_t'(1) << 99, 1'b0, "w100_dir", r, z);
      check("w100_dir_const", r, (wide_t'(1) << 100) + (wide_t'(1) << 99) - wide_t'(1));

      run_op(2, mask_of(W2), wide_t'(1), 1'b0, "w128_dir", r, z);
      check("w128_dir_const", r, wide_t'(1) << 128);

      for (int i = 0; i < 1000; i++)
         run_op(1, rand_wide(W1), rand_wide(W1), 1'($urandom_range(0, 1)), "rnd1", r, z);
      for (int i = 0; i < 1000; i++)
         run_op(2, rand_wide(W2), rand_wide(W2), 1'($urandom_range(0, 1)), "rnd2", r, z);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
